// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a registered 4:1 DW-bit mux. A hold limit forces
// rotation while other lanes wait; an uncontended lane keeps the output forever.
module mux_rr_arbiter #(
  parameter int DW       = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] data,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic [DW-1:0]   f,
  output logic            f_valid,
  output logic            busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [7:0]      hold_q, hold_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [DW-1:0]   f_q, f_d;
  logic            f_valid_q, f_valid_d;

  logic [DW-1:0]   lane [4];
  logic [1:0]      cur;
  logic [3:0]      others;
  logic            release_grant;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane[i] = data[DW*i +: DW];
  end

  // First requesting lane scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    hold_d        = hold_q;
    f_d           = f_q;
    f_valid_d     = 1'b0;
    cur           = sel_q;
    others        = req & ~(4'b0001 << cur);
    release_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_d   = pick(req, ptr_q);
          state_d = GRANT;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (req[cur]) begin
          f_d       = lane[cur];
          f_valid_d = 1'b1;
        end
        release_grant = !req[cur] || ((others != 4'b0000) && (hold_q == HOLD_LAST));
        if (release_grant) begin
          ptr_d = cur + 2'd1;
          if (others != 4'b0000) begin
            // Handover without an IDLE cycle keeps f_valid continuous.
            sel_d  = pick(req, cur + 2'd1);
            hold_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d = (state_d == GRANT) ? (4'b0001 << sel_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      f_q       <= '0;
      f_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign f       = f_q;
  assign f_valid = f_valid_q;
  assign busy    = (state_q == GRANT);

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered 4:1 DW-bit mux output between four requesters.
- Each lane presents a request and a DW-bit data value; the arbiter grants one lane at a time, drives the mux select, and registers the selected data onto f.
- A hold limit forces rotation when other lanes are waiting, so no lane can monopolise the output.
- It is the controller that sequences the 2-bit 4:1 switch mux datapath.

Parameters:
- DW, 2, width of each lane's data and of f
- MAX_HOLD, 8, max beats per grant while another lane is requesting; legal range 2..255

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  4  per-lane request, level, lane i = req[i]
- data  in  4*DW  lane i data at data[DW*i +: DW]
- gnt  out  4  one-hot grant, registered
- sel  out  2  index of granted lane, registered
- f  out  DW  registered mux output
- f_valid  out  1  f holds a beat from a granted, requesting lane
- busy  out  1  high while in GRANT

Behaviour:
- Reset (rst=0, async, any time incl. mid-grant) clears all state immediately:
  - state=IDLE, gnt=0, sel=0, f=0, f_valid=0
  - ptr (priority pointer)=0, hold_cnt=0
- Outputs:
  - gnt = (state==GRANT) ? (1<<sel) : 0
  - busy = (state==GRANT)
  - All outputs come straight from registers; no combinational path from req or data to outputs.
- Arbitration function pick(p):
  - First lane i with req[i]=1, scanning p, p+1, p+2, p+3 mod 4.
  - Defined only when req!=0.
- IDLE:
  - req==0: stay in IDLE; f_valid<=0; f holds its value.
  - req!=0: sel<=pick(ptr), state<=GRANT, hold_cnt<=0, f_valid<=0.
- GRANT, each edge, with cur=sel and other=|(req & ~(1<<cur)):
  - Beat:
    - If req[cur]=1: f<=data[cur], f_valid<=1.
    - Else f_valid<=0 and f holds its value.
  - Release when req[cur]=0, or when req[cur]=1 AND other AND hold_cnt==MAX_HOLD-1. On release:
    - ptr<=cur+1 mod 4.
    - If req & ~(1<<cur) is nonzero: sel<=pick(cur+1), hold_cnt<=0, stay in GRANT (back-to-back handover, no IDLE cycle).
    - Otherwise: state<=IDLE.
  - No release and req[cur]=1:
    - hold_cnt<=min(hold_cnt+1, MAX_HOLD-1).
    - An uncontended lane holds indefinitely.
    - hold_cnt saturates, so rotation is immediate once contention appears after saturation.
- Latency:
  - req rises in IDLE at edge n.
  - gnt/sel valid after edge n+1.
  - First f/f_valid beat after edge n+2.
- Under contention:
  - f_valid stays continuous across handover.
  - A granted lane delivers exactly MAX_HOLD beats.
- Only data[sel] is sampled; changes on non-granted lanes have no effect.
- Lane 3 wraps to lane 0 in ptr/pick.
- A lane dropping req in the same cycle another raises it: the release rule applies; the new request is visible to pick.
- f holds its last value whenever f_valid=0.

Test Plan:
- Reset mid-grant:
  - Stimulus: rst low while busy=1 with lane 2 granted.
  - Required: gnt=0, sel=0, f=0, f_valid=0, busy=0 immediately, before the next clk edge.
  - After rst releases, the first grant goes to the lowest requesting lane from ptr=0.
- Single request latency:
  - Stimulus: req=0001, data lane0=2'b10.
  - Required: gnt=0001 after edge 1; f=2'b10, f_valid=1 after edge 2; busy=1.
  - Then drop req: f_valid=0 on the following edge and busy=0.
- Fairness with all lanes requesting, MAX_HOLD=4:
  - Stimulus: req=1111 held, data lanes=00,01,10,11.
  - Required: grants cycle 0,1,2,3,0 with 4 beats each; f sequence 00x4, 01x4, 10x4, 11x4; f_valid never drops after the first beat.
- Uncontended hold:
  - Stimulus: req=0100 held for 20 cycles.
  - Required: sel=2 throughout; 19 consecutive beats; no release.
  - Then assert req[0]: handover to lane 0 on the next edge, because hold_cnt is saturated.
- Wrap and early drop:
  - Stimulus: lane 3 granted, req=1001, lane 3 drops req after 2 beats.
  - Required: next grant is lane 0 (wrap); ptr=0 afterwards; no IDLE cycle between the two grants.
- Data isolation:
  - Stimulus: toggle data on non-granted lanes every cycle while lane 1 is granted with data=2'b01.
  - Required: f stays at 2'b01.
